// File: rtl/sram_bank_pkg.sv
// Shared types and default geometry for single-port SRAM bank controllers.
// Included ahead of every file that builds or wraps a bank.
package sram_bank_pkg;

  localparam int BANK_AW = 13;
  localparam int BANK_DW = 32;

  typedef enum logic {ST_INIT, ST_RUN} bank_state_e;

endpackage

// File: rtl/sp_sram_bank_ctrl.sv
// Single-port SRAM bank front end: req/gnt/rvalid to en/we/be strobes.
// Zero-fills the bank after reset or on request and holds read data.
module sp_sram_bank_ctrl
  import sram_bank_pkg::*;
#(
  parameter int AW      = BANK_AW,
  parameter int DW      = BANK_DW,
  parameter bit INIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  input  logic            init_req_i,
  output logic            init_done_o,
  output logic            ram_en_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic            ram_we_o,
  output logic [DW/8-1:0] ram_be_o,
  output logic [DW-1:0]   ram_wdata_o,
  input  logic [DW-1:0]   ram_rdata_i
);

  bank_state_e   state_q;
  logic [AW-1:0] cnt_q;
  logic          rvalid_q;
  logic          rd_pend_q;
  logic [DW-1:0] hold_q;

  logic in_init;
  logic in_run;
  logic grant;

  // Strobes are gated by rst_n so the bank sees idle during reset.
  assign in_init = rst_n && (state_q == ST_INIT);
  assign in_run  = rst_n && (state_q == ST_RUN);
  assign grant   = in_run && req_i && !init_req_i;

  assign gnt_o       = grant;
  assign init_done_o = (state_q == ST_RUN);
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rd_pend_q ? ram_rdata_i : hold_q;

  assign ram_en_o    = in_init || grant;
  assign ram_we_o    = in_init || (in_run && we_i);
  assign ram_be_o    = in_init ? '1 : (in_run ? be_i : '0);
  assign ram_addr_o  = in_init ? cnt_q : (in_run ? addr_i : '0);
  assign ram_wdata_o = in_run ? wdata_i : '0;

  // Fill sequencer: walk every word once, then serve requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (init_req_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Response path: one-cycle rvalid, macro Q captured into the hold reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rvalid_q  <= grant;
      rd_pend_q <= grant && !we_i;
      if (rd_pend_q) hold_q <= ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_sp_sram_bank_ctrl.sv
// Bench for sp_sram_bank_ctrl with a behavioural bank macro and
// a word-level reference memory model.
module tb_sp_sram_bank_ctrl;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req_i;
  logic          gnt_o;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [3:0]    be_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          init_req_i;
  logic          init_done_o;
  logic          ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [3:0]    ram_be_o;
  logic [DW-1:0] ram_wdata_o;
  logic [DW-1:0] ram_rdata_i;

  sp_sram_bank_ctrl #(.AW(AW), .DW(DW), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .init_req_i(init_req_i), .init_done_o(init_done_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] merge(
    input logic [31:0] old_w, input logic [31:0] new_w,
    input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Bank macro: write-first, Q valid only the cycle after a strobe.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        mem[ram_addr_o] <= merge(mem[ram_addr_o], ram_wdata_o, ram_be_o);
        ram_rdata_i     <= merge(mem[ram_addr_o], ram_wdata_o, ram_be_o);
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end else begin
      ram_rdata_i <= $urandom;
    end
  end

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata;
  bit          running;
  int          passes;
  int          total;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One bus cycle: drive, check grant, clock, check response.
  task automatic cyc(input bit rq, input bit w, input logic [AW-1:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     input bit ir);
    bit g;
    bit nrv;
    logic [31:0] nrd;
    req_i = rq; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    init_req_i = ir;
    #1;
    g = running && rq && !ir;
    check("gnt", {63'd0, gnt_o}, {63'd0, g});
    check("ram_en", {63'd0, ram_en_o}, {63'd0, g});
    nrv = g;
    nrd = exp_rdata;
    if (g) begin
      check("ram_addr", {51'd0, ram_addr_o}, {51'd0, a});
      if (w) ref_mem[a] = merge(ref_mem[a], d, b);
      else nrd = ref_mem[a];
    end
    if (running && ir) running = 1'b0;
    @(posedge clk);
    #1;
    req_i = 1'b0; init_req_i = 1'b0;
    exp_rdata = nrd;
    check("rvalid", {63'd0, rvalid_o}, {63'd0, nrv});
    check("rdata", {32'd0, rdata_o}, {32'd0, exp_rdata});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // Follow a fill from count 0: strobes, stalls, duration.
  task automatic wait_fill();
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (init_done_o !== 1'b1 && n < 9000) begin
      req_i = 1'($urandom);
      we_i = 1'($urandom);
      addr_i = AW'($urandom);
      init_req_i = (n == 100);
      #1;
      if (ram_en_o !== 1'b1 || ram_we_o !== 1'b1 ||
          ram_be_o !== 4'hF || ram_wdata_o !== 32'd0 ||
          ram_addr_o !== n[AW-1:0] || gnt_o !== 1'b0 ||
          rvalid_o !== 1'b0 || rdata_o !== exp_rdata)
        bad++;
      @(posedge clk);
      #1;
      n++;
    end
    req_i = 1'b0;
    init_req_i = 1'b0;
    check("init_cycles", 64'(n), 64'(DEPTH));
    check("init_strobes", 64'(bad), 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    running = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    passes = 0; total = 0;
    running = 1'b0;
    exp_rdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = 32'd0;
    end
    rst_n = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    init_req_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {63'd0, gnt_o}, 64'd0);
    check("rst_en", {63'd0, ram_en_o}, 64'd0);
    check("rst_done", {63'd0, init_done_o}, 64'd0);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);
    req_i = 1'b0;
    rst_n = 1'b1;

    // Power-on fill, then a read at the top word
    wait_fill();
    cyc(1'b1, 1'b0, 13'h1FFF, 4'hF, '0, 1'b0);
    check("t1_top_zero", {32'd0, rdata_o}, 64'd0);

    // Full write then read with hold
    cyc(1'b1, 1'b1, 13'h0040, 4'hF, 32'hDEADBEEF, 1'b0);
    cyc(1'b1, 1'b0, 13'h0040, 4'hF, '0, 1'b0);
    check("t2_rd", {32'd0, rdata_o}, {32'd0, 32'hDEADBEEF});
    idle(10);

    // Partial byte-enable write
    cyc(1'b1, 1'b1, 13'h0040, 4'b0101, 32'h11223344, 1'b0);
    cyc(1'b1, 1'b0, 13'h0040, 4'hF, '0, 1'b0);
    check("t3_merge", {32'd0, rdata_o}, {32'd0, 32'hDE22BE44});

    // Streams, write-then-read, zero byte enables
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b1, AW'(13'h100 + i), 4'hF, $urandom, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, AW'(13'h100 + i), 4'hF, '0, 1'b0);
    cyc(1'b1, 1'b1, 13'h0200, 4'hF, 32'hA5A55A5A, 1'b0);
    cyc(1'b1, 1'b0, 13'h0200, 4'hF, '0, 1'b0);
    cyc(1'b1, 1'b1, 13'h0040, 4'h0, 32'hFFFFFFFF, 1'b0);
    cyc(1'b1, 1'b0, 13'h0040, 4'hF, '0, 1'b0);
    check("t4_be0", {32'd0, rdata_o}, {32'd0, 32'hDE22BE44});

    // Random traffic over a small window
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 3) != 0), 1'($urandom),
          AW'(13'h300 + $urandom_range(0, 31)), 4'($urandom),
          $urandom, 1'b0);

    // Re-init requested alongside a request
    cyc(1'b1, 1'b1, 13'h0055, 4'hF, 32'hCAFEF00D, 1'b0);
    cyc(1'b1, 1'b0, 13'h0055, 4'hF, '0, 1'b0);
    cyc(1'b1, 1'b0, 13'h0055, 4'hF, '0, 1'b1);
    check("t5_last_rd", {32'd0, rdata_o}, {32'd0, 32'hCAFEF00D});
    wait_fill();
    cyc(1'b1, 1'b0, 13'h0055, 4'hF, '0, 1'b0);
    check("t5_cleared", {32'd0, rdata_o}, 64'd0);

    // Reset in the middle of a fill
    cyc(1'b1, 1'b1, 13'h0060, 4'hF, 32'h12345678, 1'b0);
    cyc(1'b1, 1'b0, 13'h0060, 4'hF, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (12'h800) @(posedge clk);
    #1;
    check("t6_cnt", {51'd0, ram_addr_o}, 64'h800);
    req_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_en", {63'd0, ram_en_o}, 64'd0);
    check("t6_we", {63'd0, ram_we_o}, 64'd0);
    check("t6_be", {60'd0, ram_be_o}, 64'd0);
    check("t6_addr", {51'd0, ram_addr_o}, 64'd0);
    check("t6_gnt", {63'd0, gnt_o}, 64'd0);
    check("t6_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("t6_rdata", {32'd0, rdata_o}, 64'd0);
    check("t6_done", {63'd0, init_done_o}, 64'd0);
    req_i = 1'b0;
    exp_rdata = 32'd0;
    running = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_fill();
    cyc(1'b1, 1'b0, 13'h0060, 4'hF, '0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
